// File: rtl/elevator_pkg.sv
// Shared elevator types and defaults: floor index type, default sizing and
// the lowest-set-bit helper used to pick which pending request to report.
package elevator_pkg;

    localparam int N_FLOOR_DEF    = 8;
    localparam int DEB_CYCLES_DEF = 4;

    typedef logic [3:0] floor_idx_t;

    localparam floor_idx_t FLOOR_NONE = 4'hF;

    // Returns FLOOR_NONE for an empty mask; callers gate with |mask because 15 is also a real floor.
    function automatic floor_idx_t lowest_set(input logic [15:0] mask);
        floor_idx_t idx;
        idx = FLOOR_NONE;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                idx = floor_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/floor_button_input_if.sv
// Valid/ready channel that carries newly pressed floors to the controller.
interface floor_req_if;
    import elevator_pkg::*;

    logic       req_valid;
    floor_idx_t req_floor;
    logic       req_ready;

    modport master (output req_valid, output req_floor, input req_ready);
    modport slave  (input req_valid, input req_floor, output req_ready);

endinterface

// File: rtl/floor_button_input_debounce.sv
// Per-button 2-flop synchroniser and stable-count debouncer; o_rise marks the
// cycle on which the debounced level is about to go 0->1.
module btn_debounce
    import elevator_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = 8
) (
    input  logic ck,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_deb,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = (r_cnt == CNT_TC);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_deb) begin
                r_cnt <= '0;
            end else if (w_tc) begin
                r_deb <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Decoded from the counter so the consumer can act on the same edge deb flips.
    assign o_rise = r_s2 & ~r_deb & w_tc;
    assign o_deb  = r_deb;

endmodule

// File: rtl/floor_button_input.sv
// Floor button front end: debounced presses latch per-floor requests, arrivals
// clear them, new presses are reported lowest-first. Option: BTN_CANCEL_EN.
module floor_button_input
    import elevator_pkg::*;
#(
    parameter int N_FLOOR    = N_FLOOR_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = 8
) (
    input  logic               ck,
    input  logic               rst_n,
    input  logic [N_FLOOR-1:0] btn_raw,
    input  floor_idx_t         floor,
    input  logic               arrive,
    output logic [N_FLOOR-1:0] floor_btn,
    floor_req_if.master        req
);

    logic [N_FLOOR-1:0] w_deb;
    logic [N_FLOOR-1:0] w_rise;
    logic [N_FLOOR-1:0] w_press;
    logic [N_FLOOR-1:0] r_floor_btn;
    logic [N_FLOOR-1:0] r_new;
    logic [N_FLOOR-1:0] w_btn_nxt;
    logic [N_FLOOR-1:0] w_new_nxt;
    floor_idx_t         w_lowest;

    for (genvar g = 0; g < N_FLOOR; g++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_deb (
            .ck     (ck),
            .rst_n  (rst_n),
            .i_raw  (btn_raw[g]),
            .o_deb  (w_deb[g]),
            .o_rise (w_rise[g])
        );
    end

    assign w_press = w_rise & ~w_deb;

    always_comb begin
        w_btn_nxt = r_floor_btn;
        w_new_nxt = r_new;
        if (req.req_valid && req.req_ready) begin
            for (int i = 0; i < N_FLOOR; i++) begin
                if (req.req_floor == 4'(i)) begin
                    w_new_nxt[i] = 1'b0;
                end
            end
        end
        // Out-of-range arrival floors match no bit and so change nothing.
        for (int i = 0; i < N_FLOOR; i++) begin
            if (arrive && (floor == 4'(i))) begin
                w_btn_nxt[i] = 1'b0;
                w_new_nxt[i] = 1'b0;
            end else if (w_press[i]) begin
`ifdef BTN_CANCEL_EN
                if (r_floor_btn[i]) begin
                    w_btn_nxt[i] = 1'b0;
                    w_new_nxt[i] = 1'b0;
                end else begin
                    w_btn_nxt[i] = 1'b1;
                    w_new_nxt[i] = 1'b1;
                end
`else
                if (!r_floor_btn[i]) begin
                    w_btn_nxt[i] = 1'b1;
                    w_new_nxt[i] = 1'b1;
                end
`endif
            end
        end
    end

    assign w_lowest = lowest_set(16'(w_new_nxt));

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_floor_btn   <= '0;
            r_new         <= '0;
            req.req_valid <= 1'b0;
            req.req_floor <= '0;
        end else begin
            r_floor_btn   <= w_btn_nxt;
            r_new         <= w_new_nxt;
            req.req_valid <= |w_new_nxt;
            req.req_floor <= (|w_new_nxt) ? w_lowest : '0;
        end
    end

    assign floor_btn = r_floor_btn;

endmodule

// File: tb/tb_floor_button_input.sv
// Directed bench for floor_button_input with 8 floors and a 4-sample debounce.
module tb_floor_button_input;
    import elevator_pkg::*;

    logic       ck = 1'b0;
    logic       rst_n;
    logic [7:0] btn_raw;
    floor_idx_t floor;
    logic       arrive;
    logic [7:0] floor_btn;
    logic [7:0] exp_repress;
    int         n_checks = 0;
    int         n_errors = 0;

    floor_req_if u_req ();

    floor_button_input #(
        .N_FLOOR    (8),
        .DEB_CYCLES (4),
        .CNT_W      (8)
    ) u_dut (
        .ck        (ck),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .floor     (floor),
        .arrive    (arrive),
        .floor_btn (floor_btn),
        .req       (u_req)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic pulse_arrive(input floor_idx_t f);
        floor  = f;
        arrive = 1'b1;
        tick(1);
        arrive = 1'b0;
    endtask

    initial begin
`ifdef BTN_CANCEL_EN
        exp_repress = 8'h00;
`else
        exp_repress = 8'h40;
`endif
        rst_n           = 1'b0;
        btn_raw         = 8'h00;
        floor           = 4'd0;
        arrive          = 1'b0;
        u_req.req_ready = 1'b0;
        #1;
        chk("rst_floor_btn", 32'(floor_btn), 32'h00);
        chk("rst_valid", 32'(u_req.req_valid), 32'h0);
        chk("rst_req_floor", 32'(u_req.req_floor), 32'h0);
        tick(2);
        rst_n = 1'b1;

        // single press on floor 3, lit on edge 6
        btn_raw = 8'h08;
        tick(5);
        chk("p3_edge5_btn", 32'(floor_btn), 32'h00);
        chk("p3_edge5_valid", 32'(u_req.req_valid), 32'h0);
        tick(1);
        chk("p3_edge6_btn", 32'(floor_btn), 32'h08);
        chk("p3_valid", 32'(u_req.req_valid), 32'h1);
        chk("p3_req_floor", 32'(u_req.req_floor), 32'h3);
        u_req.req_ready = 1'b1;
        tick(1);
        u_req.req_ready = 1'b0;
        chk("p3_acc_valid", 32'(u_req.req_valid), 32'h0);
        chk("p3_acc_btn", 32'(floor_btn), 32'h08);
        btn_raw = 8'h00;
        tick(10);
        chk("p3_release_btn", 32'(floor_btn), 32'h08);
        chk("p3_release_valid", 32'(u_req.req_valid), 32'h0);
        pulse_arrive(4'd3);
        chk("p3_arrive_btn", 32'(floor_btn), 32'h00);

        // 3-sample glitches on floor 5 never reach the debounce threshold
        for (int r = 0; r < 4; r++) begin
            btn_raw = 8'h20;
            tick(3);
            btn_raw = 8'h00;
            chk("glitch_mid_btn", 32'(floor_btn), 32'h00);
            tick(5);
            chk("glitch_btn", 32'(floor_btn), 32'h00);
            chk("glitch_valid", 32'(u_req.req_valid), 32'h0);
        end

        // simultaneous presses on 2 and 5, ready held
        u_req.req_ready = 1'b1;
        btn_raw         = 8'h24;
        tick(6);
        chk("dual_btn", 32'(floor_btn), 32'h24);
        chk("dual_valid0", 32'(u_req.req_valid), 32'h1);
        chk("dual_floor0", 32'(u_req.req_floor), 32'h2);
        tick(1);
        chk("dual_valid1", 32'(u_req.req_valid), 32'h1);
        chk("dual_floor1", 32'(u_req.req_floor), 32'h5);
        tick(1);
        chk("dual_valid2", 32'(u_req.req_valid), 32'h0);
        chk("dual_btn_after", 32'(floor_btn), 32'h24);
        u_req.req_ready = 1'b0;
        btn_raw         = 8'h00;
        tick(10);

        // arrival clears, out-of-range arrival ignored
        pulse_arrive(4'd5);
        chk("arr5_btn", 32'(floor_btn), 32'h04);
        pulse_arrive(4'd9);
        chk("arr9_btn", 32'(floor_btn), 32'h04);
        chk("arr9_valid", 32'(u_req.req_valid), 32'h0);
        pulse_arrive(4'd2);
        chk("arr2_btn", 32'(floor_btn), 32'h00);

        // press on floor 1 completing on the arrival edge is dropped
        btn_raw = 8'h02;
        tick(5);
        floor  = 4'd1;
        arrive = 1'b1;
        tick(1);
        arrive = 1'b0;
        chk("arrpress_btn", 32'(floor_btn), 32'h00);
        chk("arrpress_valid", 32'(u_req.req_valid), 32'h0);
        tick(3);
        chk("arrpress_btn_late", 32'(floor_btn), 32'h00);
        chk("arrpress_valid_late", 32'(u_req.req_valid), 32'h0);
        btn_raw = 8'h00;
        tick(10);

        // re-press of a lit floor 6
        btn_raw = 8'h40;
        tick(6);
        chk("p6_btn", 32'(floor_btn), 32'h40);
        chk("p6_floor", 32'(u_req.req_floor), 32'h6);
        u_req.req_ready = 1'b1;
        tick(1);
        u_req.req_ready = 1'b0;
        chk("p6_acc_valid", 32'(u_req.req_valid), 32'h0);
        btn_raw = 8'h00;
        tick(10);
        btn_raw = 8'h40;
        tick(6);
        chk("repress_btn", 32'(floor_btn), exp_repress);
        chk("repress_valid", 32'(u_req.req_valid), 32'h0);
        tick(2);
        chk("repress_btn_hold", 32'(floor_btn), exp_repress);
        chk("repress_valid_hold", 32'(u_req.req_valid), 32'h0);
        btn_raw = 8'h00;
        tick(10);
        pulse_arrive(4'd6);
        chk("p6_clear_btn", 32'(floor_btn), 32'h00);

        // reset mid-debounce with buttons held
        btn_raw = 8'h80;
        tick(6);
        chk("p7_btn", 32'(floor_btn), 32'h80);
        chk("p7_valid", 32'(u_req.req_valid), 32'h1);
        btn_raw = 8'h81;
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("midrst_btn", 32'(floor_btn), 32'h00);
        chk("midrst_valid", 32'(u_req.req_valid), 32'h0);
        chk("midrst_floor", 32'(u_req.req_floor), 32'h0);
        tick(2);
        chk("midrst_hold_valid", 32'(u_req.req_valid), 32'h0);
        rst_n = 1'b1;
        tick(5);
        chk("postrst_edge5_btn", 32'(floor_btn), 32'h00);
        tick(1);
        chk("postrst_edge6_btn", 32'(floor_btn), 32'h81);
        chk("postrst_valid", 32'(u_req.req_valid), 32'h1);
        chk("postrst_floor", 32'(u_req.req_floor), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/floor_button_input.md
Name: floor_button_input

Overview:
- Input-side counterpart to the elevator display path.
- Synchronises and debounces the raw hall/car floor buttons, then latches one pending-request bit per floor.
- Drives `floor_btn[7:0]`, which is consumed by the display and the controller.
- Clears a floor's request when the car arrives there.
- Reports each newly pressed floor to the controller over a valid/ready handshake.

Parameters:
- `N_FLOOR`, 8, number of floors/buttons; legal range 2..16.
- `DEB_CYCLES`, 4, consecutive stable synchronised samples required before the debounced level changes; legal range 2..255.
- `CNT_W`, 8, debounce counter width; must satisfy 2^`CNT_W` > `DEB_CYCLES`.

Ports:
- `ck`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `btn_raw`  in  `N_FLOOR`  raw button levels; asynchronous; 1 = pressed.
- `floor`  in  4  current car floor.
- `arrive`  in  1  one-cycle pulse: car stopped at `floor`, doors opening.
- `floor_btn`  out  `N_FLOOR`  pending request per floor; 1 = lit/pending.
- `req_valid`  out  1  at least one unreported new request exists.
- `req_floor`  out  4  lowest-indexed unreported new request; meaningful only while `req_valid` = 1.
- `req_ready`  in  1  controller accepts `req_floor` this cycle.

Behaviour:
- Clock and reset are decided: one clock `ck`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - sync flops 0, debounced levels 0, counters 0;
  - `floor_btn` = 0, new-mask = 0;
  - `req_valid` = 0, `req_floor` = 0.
  - Reset mid-press: the button must be re-debounced from 0 after release of reset. No spurious request is issued while reset is asserted.
- Synchroniser: 2-flop chain per button (s1, s2).
- Debounce, per button, with state deb and cnt:
  - s2 == deb: cnt <= 0.
  - s2 != deb and cnt == `DEB_CYCLES`-1: deb <= s2, cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - Any glitch shorter than `DEB_CYCLES` samples restarts the count and is filtered.
- Latency: if `btn_raw[i]` is first sampled high at edge 1 and held, deb[i] rises at edge `DEB_CYCLES`+2. `floor_btn[i]` sets on that same edge (set condition is computed from the counter, not a delayed edge detect).
- Per-button press event = deb 0->1 transition. Releases (1->0) produce no event.
- On a press event for floor i:
  - `floor_btn[i]` <= 1 and new[i] <= 1.
  - Exception: if `arrive` = 1 and `floor` == i in the same cycle, the press is ignored (car is already there).
- On `arrive` with `floor` < `N_FLOOR`: `floor_btn[floor]` <= 0 and new[floor] <= 0.
- `arrive` with `floor` >= `N_FLOOR`: ignored. No X propagation; no bits change.
- Press on an already-lit floor: no state change; no second report.
- Handshake:
  - `req_valid` = |new. `req_floor` = index of the lowest set bit of new. Both registered outputs.
  - On the cycle `req_valid` && `req_ready`, new[`req_floor`] <= 0; `floor_btn` is unchanged.
  - `req_ready` with `req_valid` = 0 has no effect.
  - A press event on a different floor in the handshake cycle is retained.
  - While `req_valid` = 1 and `req_ready` = 0, `req_floor` must stay stable, except when a lower-indexed press arrives or `arrive` clears the reported floor. Either case is legal and re-selects.
- Simultaneous press and accept on the same floor: set wins (new[i] stays 1).
- Multiple simultaneous presses are all latched in one cycle and reported lowest index first, one per accepted handshake.

Optional Feature:
- Macro: `BTN_CANCEL_EN`.
- Defined: a press event on a floor whose `floor_btn` bit is already 1 clears both that bit and new[i]; the arrival-cycle rule still applies.
- Undefined: re-press of a lit floor is ignored (behaviour above).

Decomposition:
- Shared package `elevator_pkg`:
  - `N_FLOOR_DEF` = 8;
  - floor index type (4-bit);
  - `DEB_CYCLES_DEF`;
  - `FLOOR_NONE` = 4'hF.
- One natural sub-module: `btn_debounce`, instantiated once per floor via generate. It contains the 2-flop synchroniser plus counter and outputs deb and a rise pulse.
- The top level holds `floor_btn`, the new-mask, the priority encoder and the handshake.

Test Plan (`DEB_CYCLES`=4, `N_FLOOR`=8):
- Reset then `btn_raw`=8'h08 held: `floor_btn` goes 8'h08 at edge 6, `req_valid`=1, `req_floor`=3; `req_ready` pulse -> `req_valid`=0 next cycle, `floor_btn` still 8'h08.
- 3-cycle glitch on `btn_raw[5]`, repeated with gaps: `floor_btn` stays 0 and `req_valid` stays 0 throughout.
- `btn_raw`=8'h24 pressed together, `req_ready` held 1: `req_floor` sequence 2 then 5 on consecutive cycles, then `req_valid`=0; `floor_btn`=8'h24.
- `floor_btn`=8'h24, `arrive` pulse with `floor`=5: `floor_btn`=8'h04 next cycle. With `floor`=9: no change.
- Press on floor 1 whose debounce completes in the same cycle as `arrive` with `floor`=1: `floor_btn[1]` remains 0 and no report is issued.
- `BTN_CANCEL_EN` defined, floor 6 lit: release, then re-press held 6+ cycles -> `floor_btn[6]`=0 and new[6]=0. Undefined -> stays 1 with no second report.
- `rst_n` pulsed low mid-debounce with `btn_raw[0]` held: all outputs 0 immediately; `floor_btn[0]` sets 6 edges after deassertion.
